bounce_generator: RTL and testbench

//  Contact-bounce emulator: the driving end of the Debouncer input path.
//  - Turns a clean level (CleanIn) into a bouncy signal (BounceOut).
//  - Each accepted level change is followed by a BounceTime-cycle chatter window, then the new level holds.
//  - Used for on-board (Basys3) self-test loopback into Debouncer and as a reusable bench stimulus source.

---
 rtl/bounce_generator.sv | 131 +++++++++++++
 tb/tb_bounce_generator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_generator.sv
// ============================================================================
//  Module      : bounce_generator
//  Description : Contact-bounce emulator. Turns a clean level (CleanIn) into a
//                bouncy signal (BounceOut): every accepted level change opens a
//                BounceTime-cycle chatter window, after which the new level
//                holds. Feeds the Debouncer input path for loopback self-test
//                and serves as a reusable bench stimulus source.
//  Ports       : Clk       - system clock, rising edge
//                Reset     - asynchronous, active-low reset
//                CleanIn   - clean command level (button model)
//                Enable    - 1 = emulate bounce, 0 = registered pass-through
//                BounceOut - emulated noisy contact output (registered)
//                Busy      - high while the chatter window is open
//                Done      - one-cycle pulse when BounceOut settles
//  Options     : BOUNCE_LFSR_EN - chatter bits come from a 16-bit Fibonacci
//                LFSR (x^16+x^14+x^13+x^11+1); otherwise the output strictly
//                toggles every cycle inside the window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bounce_generator #(
  parameter int          CounterWidth = 2,
  parameter int          BounceTime   = 3,
  parameter logic [15:0] LfsrSeed     = 16'hACE1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic CleanIn,
  input  logic Enable,
  output logic BounceOut,
  output logic Busy,
  output logic Done
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] BOUNCE = 1'b1;

  localparam logic [CounterWidth-1:0] COUNT_ONE  = CounterWidth'(1);
  localparam logic [CounterWidth-1:0] COUNT_LAST = CounterWidth'(BounceTime);

  // The window counter must reach BounceTime without wrapping.
  if (BounceTime >= (2 ** CounterWidth)) begin : g_bad_bounce_time
    $error("bounce_generator: BounceTime must be < 2**CounterWidth");
  end

  logic [0:0]              state;
  logic                    target;
  logic [CounterWidth-1:0] count;
  logic                    pattern;

`ifdef BOUNCE_LFSR_EN
  // An all-zero seed would lock the LFSR, so it is substituted.
  localparam logic [15:0] LFSR_INIT = (LfsrSeed == 16'h0000) ? 16'h0001 : LfsrSeed;

  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lfsr <= LFSR_INIT;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  assign pattern = lfsr[0];
`else
  assign pattern = ~BounceOut;
`endif

  assign Busy = (state == BOUNCE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      target    <= 1'b0;
      count     <= '0;
      BounceOut <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (!Enable) begin
            target    <= CleanIn;
            BounceOut <= CleanIn;
          end else if (CleanIn != target) begin
            // First edge of the window already shows the new level.
            target    <= CleanIn;
            BounceOut <= CleanIn;
            if (BounceTime == 0) begin
              Done <= 1'b1;
            end else begin
              count <= COUNT_ONE;
              state <= BOUNCE;
            end
          end
        end
        BOUNCE: begin
          if (!Enable) begin
            // Abort: drop straight back to pass-through, no settle pulse.
            state     <= IDLE;
            target    <= CleanIn;
            BounceOut <= CleanIn;
          end else if (CleanIn != target) begin
            // Level changed again mid-window: restart the window.
            target    <= CleanIn;
            BounceOut <= CleanIn;
            count     <= COUNT_ONE;
          end else if (count == COUNT_LAST) begin
            BounceOut <= target;
            state     <= IDLE;
            Done      <= 1'b1;
          end else begin
            BounceOut <= pattern;
            count     <= count + COUNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bounce_generator.sv
// ============================================================================
//  Module      : tb_bounce_generator
//  Description : Self-checking bench for bounce_generator. Directed sequences
//                for reset, settle, retrigger, pass-through and async reset,
//                then randomized stimulus compared against a window-age model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bounce_generator;

  localparam int          CW   = 2;
  localparam int          BT   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic Clk;
  logic Reset;
  logic CleanIn;
  logic Enable;
  logic BounceOut;
  logic Busy;
  logic Done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: level last accepted, whether a window is open, and how
  // many edges have passed since it opened.
  logic        m_level;
  logic        m_out;
  logic        m_done;
  logic        m_active;
  int          m_age;
  logic [15:0] m_lfsr;

  bounce_generator #(
    .CounterWidth (CW),
    .BounceTime   (BT),
    .LfsrSeed     (SEED)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .CleanIn   (CleanIn),
    .Enable    (Enable),
    .BounceOut (BounceOut),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level  = 1'b0;
    m_out    = 1'b0;
    m_done   = 1'b0;
    m_active = 1'b0;
    m_age    = 0;
    m_lfsr   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  endtask

  task automatic model_edge(input logic ci, input logic en);
    logic pat;
`ifdef BOUNCE_LFSR_EN
    pat = m_lfsr[0];
`else
    pat = ~m_out;
`endif
    m_done = 1'b0;
    if (!en) begin
      m_active = 1'b0;
      m_level  = ci;
      m_out    = ci;
    end else if (ci != m_level) begin
      m_level = ci;
      m_out   = ci;
      if (BT == 0) begin
        m_done = 1'b1;
      end else begin
        m_active = 1'b1;
        m_age    = 0;
      end
    end else if (m_active) begin
      m_age++;
      if (m_age == BT) begin
        m_out    = m_level;
        m_done   = 1'b1;
        m_active = 1'b0;
      end else begin
        m_out = pat;
      end
    end
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  endtask

  // Drive inputs away from the edge, clock once, compare outputs to model.
  task automatic step(input logic ci, input logic en);
    CleanIn = ci;
    Enable  = en;
    @(posedge Clk);
    model_edge(ci, en);
    #1;
    check("model_out",  {31'd0, BounceOut}, {31'd0, m_out});
    check("model_busy", {31'd0, Busy},      {31'd0, m_active});
    check("model_done", {31'd0, Done},      {31'd0, m_done});
  endtask

  // Assert reset between edges and verify outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check({tag, "_out"},  {31'd0, BounceOut}, 32'd0);
    check({tag, "_busy"}, {31'd0, Busy},      32'd0);
    check({tag, "_done"}, {31'd0, Done},      32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    // This edge is out of reset only if Reset rose before it; it did, so
    // account for it in the model with the inputs currently applied.
    model_edge(CleanIn, Enable);
    #1;
  endtask

  logic [3:0] exp_out;
  logic [3:0] exp_busy;
  logic [3:0] exp_done;

  initial begin
    Reset   = 1'b1;
    CleanIn = 1'b1;
    Enable  = 1'b1;
    model_reset();

    // 1. Reset with CleanIn=1 forces outputs low before any edge.
    #1;
    Reset = 1'b0;
    #1;
    check("rst_out",  {31'd0, BounceOut}, 32'd0);
    check("rst_busy", {31'd0, Busy},      32'd0);
    check("rst_done", {31'd0, Done},      32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    model_reset();

    // Rising window: 1,0,1,1 with Busy on edges 0..2, Done on edge 3.
    exp_out  = 4'b1101;
    exp_busy = 4'b0111;
    exp_done = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
`ifndef BOUNCE_LFSR_EN
      check("rise_out",  {31'd0, BounceOut}, {31'd0, exp_out[i]});
`endif
      check("rise_busy", {31'd0, Busy}, {31'd0, exp_busy[i]});
      check("rise_done", {31'd0, Done}, {31'd0, exp_done[i]});
    end
    step(1'b1, 1'b1);
    check("rise_hold_done", {31'd0, Done}, 32'd0);

    // 2. Falling window: 0,1,0,0 with a single Done on edge 3.
    exp_out = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
`ifndef BOUNCE_LFSR_EN
      check("fall_out", {31'd0, BounceOut}, {31'd0, exp_out[i]});
`endif
      check("fall_done", {31'd0, Done}, {31'd0, exp_done[i]});
    end
    step(1'b0, 1'b1);
    check("fall_hold_done", {31'd0, Done}, 32'd0);

    // 3. Retrigger: 0->1 then back to 0 on edge 1; settle 0 at edge 4.
    step(1'b1, 1'b1);
    check("retrig_e0_out", {31'd0, BounceOut}, 32'd1);
    step(1'b0, 1'b1);
    check("retrig_e1_out", {31'd0, BounceOut}, 32'd0);
    check("retrig_e1_cnt", {30'd0, dut.count}, 32'd1);
    check("retrig_e1_done", {31'd0, Done}, 32'd0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("retrig_e3_done", {31'd0, Done}, 32'd0);
    step(1'b0, 1'b1);
    check("retrig_e4_out",  {31'd0, BounceOut}, 32'd0);
    check("retrig_e4_done", {31'd0, Done}, 32'd1);
    check("retrig_e4_busy", {31'd0, Busy}, 32'd0);

    // 4. Pass-through: BounceOut follows CleanIn one edge later.
    exp_out = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      step(exp_out[i], 1'b0);
      check("pass_out",  {31'd0, BounceOut}, {31'd0, exp_out[i]});
      check("pass_busy", {31'd0, Busy}, 32'd0);
      check("pass_done", {31'd0, Done}, 32'd0);
    end

    // 5. Async reset mid-window.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("mid_busy_pre", {31'd0, Busy}, 32'd1);
    async_reset("mid_rst");

    // Randomized stimulus against the model, with occasional async resets.
    for (int i = 0; i < 600; i++) begin
      logic ci;
      logic en;
      ci = ($urandom_range(0, 3) == 0) ? ~m_level : m_level;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 79) == 0) begin
        CleanIn = ci;
        Enable  = en;
        async_reset("rand_rst");
      end else begin
        step(ci, en);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
